// File: rtl/player_mover.sv
// player_mover: steps the sprite one STEP in a one-hot key direction, rejecting off-screen moves.
// Define PLAYER_MOVER_COLLIDE_EN to also check two leading-edge maze tiles before committing.
module player_mover #(
    parameter int STEP    = 2,
    parameter int START_H = 36,
    parameter int START_V = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step_tick,
    input  logic [3:0] dir,
    output logic       tile_rd,
    output logic [8:0] tile_addr,
    input  logic       tile_wall,
    output logic [9:0] pos_h,
    output logic [9:0] pos_v,
    output logic [1:0] facing,
    output logic [1:0] anim_step,
    output logic       busy,
    output logic       moved,
    output logic       blocked
);

    typedef enum logic [1:0] {IDLE, RD0, RD1, EVAL} state_t;

    logic [9:0] pos_h_q, pos_v_q;
    logic [1:0] facing_q, anim_q;
    logic       busy_q, moved_q, blocked_q, tile_rd_q;
    logic [8:0] tile_addr_q;

    // Candidate position is signed and two bits wider so underflow shows up as negative.
    logic signed [11:0] ch, cv;
    logic [1:0]         face_d;
    logic               onehot, in_bounds;

    always_comb begin
        ch     = $signed({2'b00, pos_h_q});
        cv     = $signed({2'b00, pos_v_q});
        face_d = facing_q;
        onehot = 1'b1;
        case (dir)
            4'b1000: begin cv = cv - 12'(STEP); face_d = 2'b00; end
            4'b0100: begin cv = cv + 12'(STEP); face_d = 2'b01; end
            4'b0010: begin ch = ch - 12'(STEP); face_d = 2'b10; end
            4'b0001: begin ch = ch + 12'(STEP); face_d = 2'b11; end
            default: onehot = 1'b0;
        endcase
        in_bounds = (ch >= 0) && (ch <= 12'sd624) && (cv >= 0) && (cv <= 12'sd464);
    end

`ifdef PLAYER_MOVER_COLLIDE_EN
    state_t     state_q;
    logic [9:0] cand_h_q, cand_v_q;
    logic [8:0] addr_b_q;
    logic       wall_a_q;
    logic [4:0] col_l, col_r, row_t, row_b;
    logic [8:0] addr_a, addr_b;

    function automatic logic [8:0] tile_index(input logic [4:0] col, input logic [4:0] row);
        logic [13:0] t;
        t = 14'(row) * 14'd20 + 14'(col);
        return 9'(t);
    endfunction

    always_comb begin
        col_l = ch[9:5];
        col_r = 5'((ch[9:0] + 10'd15) >> 5);
        row_t = cv[9:5];
        row_b = 5'((cv[9:0] + 10'd15) >> 5);
        case (face_d)
            2'b00: begin addr_a = tile_index(col_l, row_t); addr_b = tile_index(col_r, row_t); end
            2'b01: begin addr_a = tile_index(col_l, row_b); addr_b = tile_index(col_r, row_b); end
            2'b10: begin addr_a = tile_index(col_l, row_t); addr_b = tile_index(col_l, row_b); end
            default: begin addr_a = tile_index(col_r, row_t); addr_b = tile_index(col_r, row_b); end
        endcase
    end
`else
    logic unused_tile_wall;
    assign unused_tile_wall = tile_wall;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_h_q     <= 10'(START_H);
            pos_v_q     <= 10'(START_V);
            facing_q    <= 2'b01;
            anim_q      <= 2'd0;
            busy_q      <= 1'b0;
            moved_q     <= 1'b0;
            blocked_q   <= 1'b0;
            tile_rd_q   <= 1'b0;
            tile_addr_q <= 9'd0;
`ifdef PLAYER_MOVER_COLLIDE_EN
            state_q  <= IDLE;
            cand_h_q <= 10'd0;
            cand_v_q <= 10'd0;
            addr_b_q <= 9'd0;
            wall_a_q <= 1'b0;
`endif
        end else begin
            moved_q   <= 1'b0;
            blocked_q <= 1'b0;
            tile_rd_q <= 1'b0;
`ifdef PLAYER_MOVER_COLLIDE_EN
            case (state_q)
                IDLE: if (step_tick && onehot) begin
                    facing_q <= face_d;
                    if (in_bounds) begin
                        cand_h_q    <= ch[9:0];
                        cand_v_q    <= cv[9:0];
                        tile_rd_q   <= 1'b1;
                        tile_addr_q <= addr_a;
                        addr_b_q    <= addr_b;
                        busy_q      <= 1'b1;
                        state_q     <= RD0;
                    end else begin
                        blocked_q <= 1'b1;
                    end
                end
                RD0: begin
                    tile_rd_q   <= 1'b1;
                    tile_addr_q <= addr_b_q;
                    state_q     <= RD1;
                end
                RD1: begin
                    wall_a_q <= tile_wall;
                    state_q  <= EVAL;
                end
                default: begin
                    if (wall_a_q || tile_wall) begin
                        blocked_q <= 1'b1;
                    end else begin
                        pos_h_q <= cand_h_q;
                        pos_v_q <= cand_v_q;
                        anim_q  <= anim_q + 2'd1;
                        moved_q <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
`else
            // Without collision the FSM collapses to a single-cycle commit; busy stays low.
            if (step_tick && onehot) begin
                facing_q <= face_d;
                if (in_bounds) begin
                    pos_h_q <= ch[9:0];
                    pos_v_q <= cv[9:0];
                    anim_q  <= anim_q + 2'd1;
                    moved_q <= 1'b1;
                end else begin
                    blocked_q <= 1'b1;
                end
            end
`endif
        end
    end

    assign pos_h     = pos_h_q;
    assign pos_v     = pos_v_q;
    assign facing    = facing_q;
    assign anim_step = anim_q;
    assign busy      = busy_q;
    assign moved     = moved_q;
    assign blocked   = blocked_q;
    assign tile_rd   = tile_rd_q;
    assign tile_addr = tile_addr_q;

endmodule

// File: tb/tb_player_mover.sv
// Bench for player_mover: a tile-level model predicts outcome, latency and tile reads of each step.
module tb_player_mover;
`ifdef PLAYER_MOVER_COLLIDE_EN
    localparam bit COLL = 1'b1;
`else
    localparam bit COLL = 1'b0;
`endif
    localparam int START_H = 36, START_V = 4, STEP = 2;

    logic       clk = 1'b0;
    logic       rst, step_tick, tile_rd, tile_wall;
    logic [3:0] dir;
    logic [8:0] tile_addr;
    logic [9:0] pos_h, pos_v;
    logic [1:0] facing, anim_step;
    logic       busy, moved, blocked;

    bit maze [300];
    int checks = 0, errors = 0;
    int m_h, m_v, m_face, m_anim;

    player_mover #(.STEP(STEP), .START_H(START_H), .START_V(START_V)) dut (
        .clk(clk), .rst(rst), .step_tick(step_tick), .dir(dir),
        .tile_rd(tile_rd), .tile_addr(tile_addr), .tile_wall(tile_wall),
        .pos_h(pos_h), .pos_v(pos_v), .facing(facing), .anim_step(anim_step),
        .busy(busy), .moved(moved), .blocked(blocked)
    );

    always #5 clk = ~clk;

    // One-cycle read maze; garbage on idle cycles so a mistimed sample shows up.
    always @(posedge clk)
        tile_wall <= tile_rd ? ((tile_addr < 9'd300) ? maze[tile_addr] : 1'b1) : 1'($urandom);

    initial begin
        #2ms;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int taddr(input int x, input int y);
        return (y / 32) * 20 + x / 32;
    endfunction

    task automatic model_reset();
        m_h = START_H; m_v = START_V; m_face = 1; m_anim = 0;
    endtask

    task automatic clear_maze();
        foreach (maze[i]) maze[i] = 1'b0;
    endtask

    // kind: 0 ignored, 1 off-screen, 2 moved, 3 wall
    task automatic step_check(input logic [3:0] d, input bit jiggle, input bit inject);
        int ch, cv, kind, a, b, face, expcyc;
        int nrd, nmov, nblk, mcyc, bcyc, ra, rb, ph, pv;
        logic busy1;
        ch = m_h; cv = m_v; face = m_face; kind = 1; a = 0; b = 0;
        nrd = 0; nmov = 0; nblk = 0; mcyc = 0; bcyc = 0; ra = -1; rb = -1; ph = 0; pv = 0;
        case (d)
            4'b1000: begin cv -= STEP; face = 0; a = taddr(ch, cv);      b = taddr(ch + 15, cv);      end
            4'b0100: begin cv += STEP; face = 1; a = taddr(ch, cv + 15); b = taddr(ch + 15, cv + 15); end
            4'b0010: begin ch -= STEP; face = 2; a = taddr(ch, cv);      b = taddr(ch, cv + 15);      end
            4'b0001: begin ch += STEP; face = 3; a = taddr(ch + 15, cv); b = taddr(ch + 15, cv + 15); end
            default: kind = 0;
        endcase
        if (kind != 0) begin
            if (ch < 0 || ch > 624 || cv < 0 || cv > 464) kind = 1;
            else if (COLL && (maze[a] || maze[b]))     kind = 3;
            else                                       kind = 2;
        end
        expcyc = (kind == 1 || !COLL) ? 1 : 4;

        @(negedge clk); step_tick = 1'b1; dir = d;
        @(negedge clk); step_tick = 1'b0;
        if (jiggle) dir = 4'($urandom);
        busy1 = busy;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            if (tile_rd) begin
                nrd++;
                if (nrd == 1) ra = int'(tile_addr); else rb = int'(tile_addr);
            end
            if (moved)   begin nmov++; mcyc = cyc; ph = pos_h; pv = pos_v; end
            if (blocked) begin nblk++; bcyc = cyc; end
            if (inject && cyc == 2) begin step_tick = 1'b1; dir = 4'b0100; end
            else step_tick = 1'b0;
            if (cyc < 6) @(negedge clk);
        end
        step_tick = 1'b0;

        if (kind != 0) m_face = face;
        if (kind == 2) begin m_h = ch; m_v = cv; m_anim = (m_anim + 1) % 4; end

        chk("moved_count", nmov, (kind == 2) ? 1 : 0);
        chk("blocked_count", nblk, (kind == 1 || kind == 3) ? 1 : 0);
        chk("pulse_cycle", (kind == 2) ? mcyc : ((kind == 0) ? 0 : bcyc), (kind == 0) ? 0 : expcyc);
        chk("busy_after_accept", busy1, (COLL && kind >= 2) ? 1 : 0);
        chk("tile_reads", nrd, (COLL && kind >= 2) ? 2 : 0);
        chk("addr_a", ra, (COLL && kind >= 2) ? a : -1);
        chk("addr_b", rb, (COLL && kind >= 2) ? b : -1);
        chk("pos_at_pulse", (kind == 2) ? {ph[15:0], pv[15:0]} : 0,
            (kind == 2) ? {m_h[15:0], m_v[15:0]} : 0);
        chk("pos_h", pos_h, m_h);
        chk("pos_v", pos_v, m_v);
        chk("facing", facing, m_face);
        chk("anim_step", anim_step, m_anim);
    endtask

    initial begin
        clear_maze();
        model_reset();
        step_tick = 1'b0; dir = 4'b0000;

        // Reset with a concurrent step request: reset must win.
        rst = 1'b1; step_tick = 1'b1; dir = 4'b0001;
        repeat (3) @(negedge clk);
        chk("rst_pos_h", pos_h, START_H);
        chk("rst_pos_v", pos_v, START_V);
        chk("rst_facing", facing, 1);
        chk("rst_anim", anim_step, 0);
        chk("rst_flags", {busy, moved, blocked, tile_rd}, 0);
        chk("rst_tile_addr", tile_addr, 0);
        rst = 1'b0; step_tick = 1'b0; dir = 4'b0000;

        // Basic right move, then walk to (48,4) and hit a wall in tile 2.
        step_check(4'b0001, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step_check(4'b0001, 1'b0, 1'b0);
        maze[2] = 1'b1;
        step_check(4'b0001, 1'b0, 1'b0);
        clear_maze();

        // Walk to (0,100) then try to leave the left edge.
        for (int i = 0; i < 24; i++) step_check(4'b0010, 1'b0, 1'b0);
        for (int i = 0; i < 48; i++) step_check(4'b0100, 1'b0, 1'b0);
        step_check(4'b0010, 1'b0, 1'b0);

        // Non-one-hot requests are ignored.
        step_check(4'b1001, 1'b0, 1'b0);
        step_check(4'b0000, 1'b0, 1'b0);
        step_check(4'b0111, 1'b0, 1'b0);

`ifdef PLAYER_MOVER_COLLIDE_EN
        // A tick arriving while busy is dropped.
        step_check(4'b0001, 1'b0, 1'b1);

        // Reset while in RD1 abandons the move.
        @(negedge clk); step_tick = 1'b1; dir = 4'b0001;
        @(negedge clk); step_tick = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_reset();
        chk("rd1_rst_busy", busy, 0);
        chk("rd1_rst_pulses", {moved, blocked, tile_rd}, 0);
        chk("rd1_rst_pos", {pos_h, pos_v}, {10'(START_H), 10'(START_V)});
        @(negedge clk);
        chk("rd1_rst_no_late_pulse", {moved, blocked, busy}, 0);
        chk("rd1_rst_pos_hold", {pos_h, pos_v}, {10'(START_H), 10'(START_V)});
`endif

        // Randomised walk over a sparse random maze.
        foreach (maze[i]) maze[i] = ($urandom_range(0, 7) == 0);
        for (int i = 0; i < 250; i++) begin
            logic [3:0] d;
            if ($urandom_range(0, 3) == 0) d = 4'($urandom);
            else                           d = 4'(1 << $urandom_range(0, 3));
            step_check(d, 1'b1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
